rdi_bring_up_tx_gen: RTL and testbench

- Parametrised next-generation TX side of the RDI general bring-up handshake.
- Latches the bring-up request chosen by the RDI controller and sends the matching REQ over the sideband TX path.
- Waits for the matching RSP and reports done. Adds behaviour the first generation lacks: response timeout, bounded retry on timeout or PM_NAK, explicit fail status, and a valid-held sideband handshake.
- Sits between the RDI controller and the sideband TX/RX message interfaces.

---
 rtl/rdi_bring_up_pkg.sv | 72 +++++++
 rtl/rdi_bring_up_tx_gen_if.sv | 31 +++
 rtl/rdi_bring_up_timer.sv | 39 +++
 rtl/rdi_bring_up_tx_gen.sv | 187 ++++++++++++++++++
 tb/tb_rdi_bring_up_tx_gen.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rdi_bring_up_pkg.sv
// Shared definitions for the RDI general bring-up TX generator.
// Holds the sideband message codes, the controller select codes, the FSM
// state encoding, and the select-to-message lookup helpers.
package rdi_bring_up_pkg;

    localparam int unsigned PKG_MSG_W = 4;

    // REQ codes sent toward the link partner
    localparam logic [PKG_MSG_W-1:0] REQ_ACTIVE    = 4'd1;
    localparam logic [PKG_MSG_W-1:0] REQ_RETRAIN   = 4'd6;
    localparam logic [PKG_MSG_W-1:0] REQ_LINKERROR = 4'd5;
    localparam logic [PKG_MSG_W-1:0] REQ_LINKRESET = 4'd4;
    localparam logic [PKG_MSG_W-1:0] REQ_DISABLE   = 4'd7;

    // RSP codes expected back from the link partner
    localparam logic [PKG_MSG_W-1:0] RSP_ACTIVE    = 4'd8;
    localparam logic [PKG_MSG_W-1:0] RSP_RETRAIN   = 4'd14;
    localparam logic [PKG_MSG_W-1:0] RSP_LINKERROR = 4'd13;
    localparam logic [PKG_MSG_W-1:0] RSP_LINKRESET = 4'd12;
    localparam logic [PKG_MSG_W-1:0] RSP_DISABLE   = 4'd15;
    localparam logic [PKG_MSG_W-1:0] PM_NAK        = 4'd9;

    typedef enum logic [2:0] {
        SEL_NONE      = 3'd0,
        SEL_ACTIVE    = 3'd1,
        SEL_RETRAIN   = 3'd2,
        SEL_LINKERROR = 3'd3,
        SEL_LINKRESET = 3'd4,
        SEL_DISABLE   = 3'd5
    } sel_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RX  = 3'd1,
        ST_REQ_SEND = 3'd2,
        ST_HANDLE   = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAIL     = 3'd5
    } state_e;

    // Codes 6 and 7 are not real requests; fold them onto "none".
    function automatic logic [2:0] sel_sanitize(input logic [2:0] sel);
        if (sel > 3'd5) begin
            return 3'd0;
        end else begin
            return sel;
        end
    endfunction

    function automatic logic [PKG_MSG_W-1:0] sel_to_req(input logic [2:0] sel);
        case (sel)
            SEL_ACTIVE:    return REQ_ACTIVE;
            SEL_RETRAIN:   return REQ_RETRAIN;
            SEL_LINKERROR: return REQ_LINKERROR;
            SEL_LINKRESET: return REQ_LINKRESET;
            SEL_DISABLE:   return REQ_DISABLE;
            default:       return 4'd0;
        endcase
    endfunction

    function automatic logic [PKG_MSG_W-1:0] sel_to_rsp(input logic [2:0] sel);
        case (sel)
            SEL_ACTIVE:    return RSP_ACTIVE;
            SEL_RETRAIN:   return RSP_RETRAIN;
            SEL_LINKERROR: return RSP_LINKERROR;
            SEL_LINKRESET: return RSP_LINKRESET;
            SEL_DISABLE:   return RSP_DISABLE;
            default:       return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/rdi_bring_up_tx_gen_if.sv
// Sideband message interface between the bring-up TX generator and the
// sideband TX/RX blocks.
//   o_tx_sb_message / o_tx_msg_valid : REQ toward sideband TX (valid held)
//   i_rx_done_send_message           : sideband TX accepted the REQ (pulse)
//   i_rx_sb_message / i_rx_msg_valid : message decoded by sideband RX
// master = bring-up TX generator, slave = sideband side.
interface rdi_bring_up_tx_gen_if #(
    parameter int MSG_W = 4
);
    logic [MSG_W-1:0] o_tx_sb_message;
    logic             o_tx_msg_valid;
    logic             i_rx_done_send_message;
    logic [MSG_W-1:0] i_rx_sb_message;
    logic             i_rx_msg_valid;

    modport master (
        output o_tx_sb_message,
        output o_tx_msg_valid,
        input  i_rx_done_send_message,
        input  i_rx_sb_message,
        input  i_rx_msg_valid
    );

    modport slave (
        input  o_tx_sb_message,
        input  o_tx_msg_valid,
        output i_rx_done_send_message,
        output i_rx_sb_message,
        output i_rx_msg_valid
    );
endinterface

// File: rtl/rdi_bring_up_timer.sv
// Response timeout counter.
//   lclk, sys_rst : clock, synchronous active-high reset
//   i_clear       : force count to zero (has priority over enable)
//   i_enable      : count one cycle
//   o_expire      : count has reached TIMEOUT_CYCLES-1
// The count holds once expired, so it can never wrap.
module rdi_bring_up_timer #(
    parameter int TO_W           = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic lclk,
    input  logic sys_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    logic [TO_W-1:0] r_cnt;
    logic            w_expire;

    // Terminal-count detect
    always_comb begin
        w_expire = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end

    // Counter register
    always_ff @(posedge lclk) begin
        if (sys_rst) begin
            r_cnt <= {TO_W{1'b0}};
        end else if (i_clear) begin
            r_cnt <= {TO_W{1'b0}};
        end else if (i_enable && !w_expire) begin
            r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = w_expire;
endmodule

// File: rtl/rdi_bring_up_tx_gen.sv
// RDI general bring-up TX generator: latches the controller's bring-up
// select, sends the matching REQ over sideband (valid held until accepted),
// waits for the matching RSP, and retries on timeout or PM_NAK.
//   lclk, sys_rst                    : clock, synchronous active-high reset
//   i_rdi_controller_choosen_bring_up: requested bring-up (0 none, 1..5)
//   i_rx_busy_from_RX                : local RX side busy, delay the REQ
//   sb (master)                      : sideband REQ out / RSP in
//   o_General_Bring_Up_done_TX       : matching RSP received
//   o_bring_up_fail_TX               : retries exhausted
//   o_retry_cnt                      : re-sends for the current request
// All outputs are registered from the next-state decode, so they change on
// the edge that enters the state driving them.
module rdi_bring_up_tx_gen
    import rdi_bring_up_pkg::*;
#(
    parameter int MSG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16,
    parameter int MAX_RETRY      = 3,
    parameter int RTY_W          = 2
) (
    input  logic                 lclk,
    input  logic                 sys_rst,
    input  logic [2:0]           i_rdi_controller_choosen_bring_up,
    input  logic                 i_rx_busy_from_RX,
    rdi_bring_up_tx_gen_if.master sb,
    output logic                 o_General_Bring_Up_done_TX,
    output logic                 o_bring_up_fail_TX,
    output logic [RTY_W-1:0]     o_retry_cnt
);
    state_e           r_state,   w_state_nx;
    logic [2:0]       r_latch,   w_latch_nx;
    logic [RTY_W-1:0] r_retry,   w_retry_nx;
    logic [MSG_W-1:0] r_tx_msg,  w_tx_msg_nx;
    logic             r_tx_vld,  w_tx_vld_nx;
    logic             r_done,    w_done_nx;
    logic             r_fail,    w_fail_nx;
    logic [2:0]       w_sel;
    logic             w_abort;
    logic             w_rsp_hit;
    logic             w_nak_hit;
    logic             w_expire;

    rdi_bring_up_timer #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .lclk     (lclk),
        .sys_rst  (sys_rst),
        .i_clear  (r_state != ST_HANDLE),
        .i_enable (r_state == ST_HANDLE),
        .o_expire (w_expire)
    );

    // Next-state, latch, retry and registered-output decode
    always_comb begin
        w_state_nx  = r_state;
        w_latch_nx  = r_latch;
        w_retry_nx  = r_retry;
        w_tx_msg_nx = {MSG_W{1'b0}};
        w_tx_vld_nx = 1'b0;
        w_done_nx   = 1'b0;
        w_fail_nx   = 1'b0;

        w_sel     = sel_sanitize(i_rdi_controller_choosen_bring_up);
        // The latch is never 0 outside IDLE, so a 0 select also differs.
        w_abort   = (w_sel != r_latch);
        w_rsp_hit = sb.i_rx_msg_valid && (sb.i_rx_sb_message == MSG_W'(sel_to_rsp(r_latch)));
        w_nak_hit = sb.i_rx_msg_valid && (sb.i_rx_sb_message == MSG_W'(PM_NAK));

        case (r_state)
            ST_IDLE: begin
                if (w_sel != 3'd0) begin
                    w_latch_nx = w_sel;
                    if (i_rx_busy_from_RX) begin
                        w_state_nx = ST_WAIT_RX;
                    end else begin
                        w_state_nx = ST_REQ_SEND;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_WAIT_RX: begin
                if (w_abort) begin
                    w_state_nx = ST_IDLE;
                end else if (!i_rx_busy_from_RX) begin
                    w_state_nx = ST_REQ_SEND;
                end else begin
                    w_state_nx = ST_WAIT_RX;
                end
            end
            ST_REQ_SEND: begin
                if (w_abort) begin
                    w_state_nx = ST_IDLE;
                end else if (sb.i_rx_done_send_message) begin
                    w_state_nx = ST_HANDLE;
                end else begin
                    w_state_nx = ST_REQ_SEND;
                end
            end
            ST_HANDLE: begin
                // A matching RSP beats a simultaneous timeout.
                if (w_abort) begin
                    w_state_nx = ST_IDLE;
                end else if (w_rsp_hit) begin
                    w_state_nx = ST_DONE;
                end else if (w_nak_hit || w_expire) begin
                    if (r_retry < RTY_W'(MAX_RETRY)) begin
                        w_retry_nx = r_retry + {{(RTY_W-1){1'b0}}, 1'b1};
                        w_state_nx = ST_REQ_SEND;
                    end else begin
                        w_state_nx = ST_FAIL;
                    end
                end else begin
                    w_state_nx = ST_HANDLE;
                end
            end
            ST_DONE: begin
                if (w_abort) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_FAIL: begin
                if (w_abort) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_FAIL;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered.
        case (w_state_nx)
            ST_IDLE: begin
                w_latch_nx = 3'd0;
                w_retry_nx = {RTY_W{1'b0}};
            end
            ST_REQ_SEND: begin
                w_tx_msg_nx = MSG_W'(sel_to_req(w_latch_nx));
                w_tx_vld_nx = 1'b1;
            end
            ST_DONE: begin
                w_done_nx = 1'b1;
            end
            ST_FAIL: begin
                w_fail_nx  = 1'b1;
                w_retry_nx = RTY_W'(MAX_RETRY);
            end
            default: begin
                w_tx_vld_nx = 1'b0;
            end
        endcase
    end

    // State, latch, counters and output registers
    always_ff @(posedge lclk) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_latch  <= 3'd0;
            r_retry  <= {RTY_W{1'b0}};
            r_tx_msg <= {MSG_W{1'b0}};
            r_tx_vld <= 1'b0;
            r_done   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_latch  <= w_latch_nx;
            r_retry  <= w_retry_nx;
            r_tx_msg <= w_tx_msg_nx;
            r_tx_vld <= w_tx_vld_nx;
            r_done   <= w_done_nx;
            r_fail   <= w_fail_nx;
        end
    end

    assign sb.o_tx_sb_message         = r_tx_msg;
    assign sb.o_tx_msg_valid          = r_tx_vld;
    assign o_General_Bring_Up_done_TX = r_done;
    assign o_bring_up_fail_TX         = r_fail;
    assign o_retry_cnt                = r_retry;
endmodule

// File: tb/tb_rdi_bring_up_tx_gen.sv
// Directed, table-driven bench for rdi_bring_up_tx_gen.
// Each vector gives the inputs applied before a rising edge and the outputs
// expected just after it.
module tb_rdi_bring_up_tx_gen;
    localparam int MSG_W = 4;
    localparam int TO    = 8;
    localparam int TO_W  = 16;
    localparam int MR    = 3;
    localparam int RTY_W = 2;

    logic             lclk = 1'b0;
    logic             sys_rst;
    logic [2:0]       sel;
    logic             busy;
    logic             done;
    logic             fail;
    logic [RTY_W-1:0] retry;

    always #5 lclk = ~lclk;

    rdi_bring_up_tx_gen_if #(.MSG_W(MSG_W)) sb ();

    rdi_bring_up_tx_gen #(
        .MSG_W          (MSG_W),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (TO_W),
        .MAX_RETRY      (MR),
        .RTY_W          (RTY_W)
    ) dut (
        .lclk                              (lclk),
        .sys_rst                           (sys_rst),
        .i_rdi_controller_choosen_bring_up (sel),
        .i_rx_busy_from_RX                 (busy),
        .sb                                (sb.master),
        .o_General_Bring_Up_done_TX        (done),
        .o_bring_up_fail_TX                (fail),
        .o_retry_cnt                       (retry)
    );

    typedef struct {
        string            tag;
        logic             rst;
        logic [2:0]       sel;
        logic             busy;
        logic [MSG_W-1:0] rxm;
        logic             rxv;
        logic             ds;
        logic [MSG_W-1:0] emsg;
        logic             ev;
        logic             ed;
        logic             ef;
        logic [RTY_W-1:0] er;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string tag, input int rst, input int s, input int b,
                                input int rxm, input int rxv, input int ds,
                                input int emsg, input int ev, input int ed, input int ef,
                                input int er);
        vec_t t;
        t.tag  = tag;
        t.rst  = 1'(rst);
        t.sel  = 3'(s);
        t.busy = 1'(b);
        t.rxm  = MSG_W'(rxm);
        t.rxv  = 1'(rxv);
        t.ds   = 1'(ds);
        t.emsg = MSG_W'(emsg);
        t.ev   = 1'(ev);
        t.ed   = 1'(ed);
        t.ef   = 1'(ef);
        t.er   = RTY_W'(er);
        return t;
    endfunction

    task automatic step(input vec_t t);
        sys_rst                   = t.rst;
        sel                       = t.sel;
        busy                      = t.busy;
        sb.i_rx_sb_message        = t.rxm;
        sb.i_rx_msg_valid         = t.rxv;
        sb.i_rx_done_send_message = t.ds;
        @(posedge lclk);
        #1;
        checks++;
        if ({sb.o_tx_sb_message, sb.o_tx_msg_valid, done, fail, retry} !==
            {t.emsg, t.ev, t.ed, t.ef, t.er}) begin
            errors++;
            $display("FAIL %s (check %0d): got msg=%0d vld=%0b done=%0b fail=%0b retry=%0d, want msg=%0d vld=%0b done=%0b fail=%0b retry=%0d",
                     t.tag, checks, sb.o_tx_sb_message, sb.o_tx_msg_valid, done, fail, retry,
                     t.emsg, t.ev, t.ed, t.ef, t.er);
        end
    endtask

    initial begin
        sys_rst = 1'b1; sel = 3'd0; busy = 1'b0;
        sb.i_rx_sb_message = 4'd0; sb.i_rx_msg_valid = 1'b0; sb.i_rx_done_send_message = 1'b0;

        // ---- reset state
        tbl.push_back(mk("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("reset1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ---- ACTIVE: REQ 1 held over stalls, ignored stray messages, RSP 8
        tbl.push_back(mk("act_req",    0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("act_stall", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("act_ack",    0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("act_wait",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("act_badrsp", 0, 1, 0, 14, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("act_req_in", 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("act_novld",  0, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("act_rsp",    0, 1, 0, 8, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("act_hold",   0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("act_drop",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ---- RETRAIN behind a busy RX side
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk("rtr_busy", 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rtr_req",    0, 2, 0, 0, 0, 0, 6, 1, 0, 0, 0));
        tbl.push_back(mk("rtr_ack",    0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rtr_rsp",    0, 2, 0, 14, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("rtr_inval",  0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ---- LINKRESET: one PM_NAK then RSP 12
        tbl.push_back(mk("lr_req",     0, 4, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        tbl.push_back(mk("lr_ack",     0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lr_nak",     0, 4, 0, 9, 1, 0, 4, 1, 0, 0, 1));
        tbl.push_back(mk("lr_ack2",    0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk("lr_rsp",     0, 4, 0, 12, 1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk("lr_drop",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ---- select change 1 -> 3 while in HANDLE aborts, then LINKERROR runs
        tbl.push_back(mk("ab_req",     0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("ab_ack",     0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("ab_change",  0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("le_req",     0, 3, 0, 0, 0, 0, 5, 1, 0, 0, 0));
        tbl.push_back(mk("le_ack",     0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("le_stray8",  0, 3, 0, 8, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("le_rsp",     0, 3, 0, 13, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("le_drop",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ---- reset while valid held, then invalid select keeps IDLE
        tbl.push_back(mk("rs_req",     0, 5, 0, 0, 0, 0, 7, 1, 0, 0, 0));
        tbl.push_back(mk("rs_stall",   0, 5, 0, 0, 0, 0, 7, 1, 0, 0, 0));
        tbl.push_back(mk("rs_reset",   1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rs_sel6a",   0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rs_sel6b",   0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // ---- DISABLE with no response: 3 timed-out re-sends then FAIL
        step(mk("to_req", 0, 5, 0, 0, 0, 0, 7, 1, 0, 0, 0));
        for (int r = 0; r <= MR; r++) begin
            step(mk("to_ack", 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, r));
            for (int k = 1; k < TO; k++)
                step(mk("to_wait", 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, r));
            if (r < MR)
                step(mk("to_resend", 0, 5, 0, 0, 0, 0, 7, 1, 0, 0, r + 1));
            else
                step(mk("to_fail", 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, MR));
        end
        for (int i = 0; i < 3; i++)
            step(mk("to_fail_hold", 0, 5, 0, 15, 1, 0, 0, 0, 0, 1, MR));
        step(mk("to_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ---- RSP 12 on the very cycle the timeout fires: done, no retry
        step(mk("tie_req", 0, 4, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        step(mk("tie_ack", 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 1; k < TO; k++)
            step(mk("tie_wait", 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk("tie_rsp", 0, 4, 0, 12, 1, 0, 0, 0, 1, 0, 0));
        step(mk("tie_hold", 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step(mk("tie_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
